// File: rtl/risc_prog_loader.sv
// Byte-stream program loader: parses address/count/data commands, writes CPU instruction memory, gates CPU run.
// Optional LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte per data block.
module risc_prog_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_address,
  output logic [DATA_W-1:0] inst_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE, S_RUN
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_IDLE;
`endif

  localparam logic [DATA_W-1:0] CMD_ADDR  = DATA_W'(8'hA5);
  localparam logic [DATA_W-1:0] CMD_COUNT = DATA_W'(8'h5A);
  localparam logic [DATA_W-1:0] CMD_RUN   = DATA_W'(8'hC3);
  localparam logic [DATA_W-1:0] CMD_STOP  = DATA_W'(8'h3C);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic                inst_we_q, inst_we_d;
  logic [ADDR_W-1:0]   inst_address_q, inst_address_d;
  logic [DATA_W-1:0]   inst_data_q, inst_data_d;
  logic                cpu_run_q, cpu_run_d;
  logic                err_q, err_d;
  logic                fire;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    inst_address_d = inst_address_q;
    inst_data_d    = inst_data_q;
    err_d          = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d         = csum_q;
`endif
    in_ready       = (state_q != S_WRITE);
    fire           = in_valid && in_ready;

    case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (in_data == CMD_ADDR) begin
            state_d = S_ADDR;
          end else if (in_data == CMD_COUNT) begin
            state_d = S_COUNT;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
          end else if (in_data == CMD_RUN) begin
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (fire) begin
          ptr_d   = ADDR_W'(in_data);
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (fire) begin
          cnt_d   = in_data;
          state_d = (in_data == '0) ? S_END : S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
          inst_data_d    = in_data;
          inst_address_d = ptr_q;
`ifdef LOADER_CHECKSUM_EN
          csum_d         = csum_q + 8'(in_data);
`endif
          state_d        = S_WRITE;
        end
      end
      S_WRITE: begin
        // cnt_q is at least 1 here, so "count-1 still nonzero" is cnt_q != 1
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q != DATA_W'(1)) ? S_DATA : S_END;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (fire) begin
          if (8'(in_data) != csum_q) begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
`endif
      S_RUN: begin
        if (fire && (in_data == CMD_STOP)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    inst_we_d = (state_d == S_WRITE);
    cpu_run_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      inst_we_q      <= 1'b0;
      inst_address_q <= '0;
      inst_data_q    <= '0;
      cpu_run_q      <= 1'b0;
      err_q          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      inst_we_q      <= inst_we_d;
      inst_address_q <= inst_address_d;
      inst_data_q    <= inst_data_d;
      cpu_run_q      <= cpu_run_d;
      err_q          <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign inst_we      = inst_we_q;
  assign inst_address = inst_address_q;
  assign inst_data    = inst_data_q;
  assign cpu_run      = cpu_run_q;
  assign err          = err_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_RUN);

endmodule

// File: doc/risc_prog_loader.md
RISC_PROG_LOADER -- requirements
Module: risc_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 7, instruction memory address width.
REQ-002 Parameter DATA_W, default 8, instruction byte width; in_data width equals DATA_W.
REQ-003 Port clk  input  1  sole clock; all logic samples on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream byte valid.
REQ-006 Port in_data  input  DATA_W  upstream command/data byte.
REQ-007 Port in_ready  output  1  loader accepts byte; transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 Port inst_we  output  1  one-cycle instruction memory write strobe to CPU.
REQ-009 Port inst_address  output  ADDR_W  write address, registered.
REQ-010 Port inst_data  output  DATA_W  write data, registered.
REQ-011 Port cpu_run  output  1  CPU release; CPU is held in reset while low.
REQ-012 Port busy  output  1  high in any state other than IDLE and RUN.
REQ-013 Port err  output  1  sticky protocol error flag.

Function
REQ-014 FSM states: IDLE, ADDR, COUNT, DATA, WRITE, CSUM, RUN.
REQ-015 IDLE, command 0xA5 -> ADDR; command 0x5A -> COUNT; command 0xC3 -> RUN; any other byte sets err and the FSM stays in IDLE.
REQ-016 ADDR: the accepted byte's low ADDR_W bits load the address pointer -> IDLE.
REQ-017 COUNT: the accepted byte loads remaining count; count 0 -> IDLE with no writes; otherwise -> DATA.
REQ-018 DATA: accepted byte is registered into inst_data, the pointer is registered into inst_address, then -> WRITE.
REQ-019 WRITE lasts exactly one cycle: inst_we=1, in_ready=0, pointer increments, count decrements; exits to DATA if count is still nonzero, otherwise to the block-end state.
REQ-020 Latency: data byte accepted at edge N -> inst_we high during cycle N+1; at most one write per two cycles.
REQ-021 Pointer wraps at 2^ADDR_W-1 -> 0 silently (127 -> 0 with default).
REQ-022 in_ready=1 in IDLE, ADDR, COUNT, DATA, CSUM, RUN; 0 in WRITE only.
REQ-023 inst_address and inst_data hold their last value when inst_we=0.
REQ-024 RUN: cpu_run=1; byte 0x3C -> IDLE with cpu_run=0 on the next cycle; other bytes are consumed and ignored.
REQ-025 Bytes with in_valid=0 are never consumed; a stalled stream holds state indefinitely.
REQ-026 err clears only on rst; err never blocks further operation.

Reset
REQ-027 On rst=1 at an edge: state=IDLE, pointer=0, count=0, checksum=0, inst_we=0, inst_address=0, inst_data=0, cpu_run=0, err=0; in_ready=1 on the cycle after reset.
REQ-028 rst asserted mid-block (any state, including WRITE) aborts the block; no inst_we is issued on the cycle after the reset edge.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN.
REQ-030 Defined: an 8-bit modulo-256 sum of block data bytes is kept, cleared on entry to COUNT; after the last WRITE -> CSUM; the next accepted byte is compared with the sum; a mismatch sets err; -> IDLE either way. Count 0 also passes through CSUM.
REQ-031 Undefined: no CSUM state or checksum logic; the last WRITE or count 0 -> IDLE.

Verification
REQ-032 Bytes A5,10,5A,02,11,22 -> inst_we pulses writing (0x10,0x11) then (0x11,0x22); in_ready low exactly on the write cycles.
REQ-033 A5,7F,5A,02,AA,BB -> writes (0x7F,0xAA), (0x00,0xBB) (wrap).
REQ-034 Byte 0x77 in IDLE -> err=1 and stays 1; a following C3 -> cpu_run=1; 3C -> cpu_run=0.
REQ-035 rst pulsed during the DATA byte of a 5A,03 block -> no further inst_we; all outputs match REQ-027.
REQ-036 With LOADER_CHECKSUM_EN: 5A,02,01,02,03 -> err=0; 5A,02,01,02,04 -> err=1; without the macro, 5A,02,01,02 returns to IDLE.
REQ-037 in_valid toggled randomly during the REQ-032 stream -> identical write sequence.
